// File: rtl/crypto_regfile_axi.sv
// Memory-mapped register file behind AXI-lite-style valid/ready channels; one transaction outstanding.
// Optional byte strobes on writes are enabled by defining CRYPTO_REGFILE_WSTRB_EN.
module crypto_regfile_axi #(
  parameter int unsigned           DATA_W    = 32,
  parameter int unsigned           ADDR_W    = 38,
  parameter int unsigned           NUM_REGS  = 16,
  parameter logic [ADDR_W-1:0]     BASE_ADDR = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 wraddr_valid,
  output logic                 wraddr_ready,
  input  logic [ADDR_W-1:0]    wraddr,
  input  logic                 wr_valid,
  output logic                 wr_ready,
  input  logic [DATA_W-1:0]    wr_dat,
`ifdef CRYPTO_REGFILE_WSTRB_EN
  input  logic [DATA_W/8-1:0]  wr_strb,
`endif
  output logic                 wrresp_valid,
  input  logic                 wrresp_ready,
  output logic [1:0]           wrresp_dat,
  input  logic                 rdaddr_valid,
  output logic                 rdaddr_ready,
  input  logic [ADDR_W-1:0]    rdaddr,
  output logic                 rd_valid,
  input  logic                 rd_ready,
  output logic [DATA_W-1:0]    rd_dat,
  output logic [1:0]           rdresp_dat
);

  localparam int unsigned       STRB_W     = DATA_W / 8;
  localparam int unsigned       LSB        = $clog2(STRB_W);
  localparam int unsigned       REG_IW     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);
  localparam logic [1:0]        RESP_OKAY  = 2'b00;
  localparam logic [1:0]        RESP_DEC   = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WDATA = 2'd1,
    S_WRESP = 2'd2,
    S_RDATA = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wraddr;
  logic [1:0]          r_wresp;
  logic [1:0]          r_rresp;
  logic [DATA_W-1:0]   r_rd_dat;
  logic [DATA_W-1:0]   r_regs [NUM_REGS];

  logic [ADDR_W-1:0]   w_wr_off;
  logic [ADDR_W-1:0]   w_wr_sh;
  logic                w_wr_hit;
  logic [REG_IW-1:0]   w_wr_idx;
  logic [ADDR_W-1:0]   w_rd_off;
  logic [ADDR_W-1:0]   w_rd_sh;
  logic                w_rd_hit;
  logic [REG_IW-1:0]   w_rd_idx;
  logic                w_wa_accept;
  logic                w_ra_accept;
  logic                w_wr_commit;

  // Write decode uses the latched address; read decode uses the live address at its handshake.
  always_comb begin
    w_wr_off = r_wraddr - BASE_ADDR;
    w_wr_sh  = w_wr_off >> LSB;
    w_wr_hit = (r_wraddr >= BASE_ADDR) && (w_wr_sh < NUM_REGS_A);
    w_wr_idx = w_wr_sh[REG_IW-1:0];
    w_rd_off = rdaddr - BASE_ADDR;
    w_rd_sh  = w_rd_off >> LSB;
    w_rd_hit = (rdaddr >= BASE_ADDR) && (w_rd_sh < NUM_REGS_A);
    w_rd_idx = w_rd_sh[REG_IW-1:0];
  end

  assign w_wa_accept = (r_state == S_IDLE) && wraddr_valid;
  assign w_ra_accept = (r_state == S_IDLE) && rdaddr_valid && !wraddr_valid;
  assign w_wr_commit = (r_state == S_WDATA) && wr_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = r_state;
    wraddr_ready = 1'b0;
    rdaddr_ready = 1'b0;
    wr_ready     = 1'b0;
    wrresp_valid = 1'b0;
    rd_valid     = 1'b0;
    case (r_state)
      S_IDLE: begin
        wraddr_ready = rst_n;
        rdaddr_ready = rst_n && !wraddr_valid;
        if (wraddr_valid)      w_state_nxt = S_WDATA;
        else if (rdaddr_valid) w_state_nxt = S_RDATA;
      end
      S_WDATA: begin
        wr_ready = 1'b1;
        if (wr_valid) w_state_nxt = S_WRESP;
      end
      S_WRESP: begin
        wrresp_valid = 1'b1;
        if (wrresp_ready) w_state_nxt = S_IDLE;
      end
      S_RDATA: begin
        rd_valid = 1'b1;
        if (rd_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wraddr <= '0;
      r_wresp  <= RESP_OKAY;
      r_rresp  <= RESP_OKAY;
      r_rd_dat <= '0;
    end else begin
      if (w_wa_accept) r_wraddr <= wraddr;
      if (w_wr_commit) r_wresp <= w_wr_hit ? RESP_OKAY : RESP_DEC;
      if (w_ra_accept) begin
        r_rresp  <= w_rd_hit ? RESP_OKAY : RESP_DEC;
        r_rd_dat <= w_rd_hit ? r_regs[w_rd_idx] : '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else if (w_wr_commit && w_wr_hit) begin
`ifdef CRYPTO_REGFILE_WSTRB_EN
      for (int unsigned k = 0; k < STRB_W; k++)
        if (wr_strb[k]) r_regs[w_wr_idx][8*k +: 8] <= wr_dat[8*k +: 8];
`else
      r_regs[w_wr_idx] <= wr_dat;
`endif
    end
  end

  assign wrresp_dat = r_wresp;
  assign rdresp_dat = r_rresp;
  assign rd_dat     = r_rd_dat;

endmodule

// File: tb/tb_crypto_regfile_axi.sv
// Directed table-driven bench for crypto_regfile_axi (BASE_ADDR=0x100, 16 x 32-bit registers).
module tb_crypto_regfile_axi;

  localparam int unsigned DW   = 32;
  localparam int unsigned AW   = 38;
  localparam int unsigned NR   = 16;
  localparam logic [AW-1:0] BASE = 38'h100;
  localparam int TMO = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wraddr_valid = 1'b0;
  logic          wraddr_ready;
  logic [AW-1:0] wraddr = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [DW-1:0] wr_dat = '0;
  logic [DW/8-1:0] wr_strb = '1;
  logic          wrresp_valid;
  logic          wrresp_ready = 1'b0;
  logic [1:0]    wrresp_dat;
  logic          rdaddr_valid = 1'b0;
  logic          rdaddr_ready;
  logic [AW-1:0] rdaddr = '0;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic [DW-1:0] rd_dat;
  logic [1:0]    rdresp_dat;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  crypto_regfile_axi #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst_n(rst_n),
    .wraddr_valid(wraddr_valid), .wraddr_ready(wraddr_ready), .wraddr(wraddr),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_dat(wr_dat),
`ifdef CRYPTO_REGFILE_WSTRB_EN
    .wr_strb(wr_strb),
`endif
    .wrresp_valid(wrresp_valid), .wrresp_ready(wrresp_ready), .wrresp_dat(wrresp_dat),
    .rdaddr_valid(rdaddr_valid), .rdaddr_ready(rdaddr_ready), .rdaddr(rdaddr),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_dat(rd_dat), .rdresp_dat(rdresp_dat)
  );

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [1:0]    resp;
    logic [DW-1:0] rdat;
  } vec_t;

  vec_t          vecs [14];
  logic [DW-1:0] model [NR];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_hi(input string name, ref logic sig);
    int n = 0;
    while (sig !== 1'b1 && n < TMO) begin @(negedge clk); n++; end
    if (n >= TMO) chk({name, "_timeout"}, 64'(n), 64'(TMO - 1));
  endtask

  task automatic wr_txn(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic [DW/8-1:0] s,
                        input int stall, output logic [1:0] resp);
    @(negedge clk);
    wraddr = a; wraddr_valid = 1'b1;
    wait_hi("wraddr_ready", wraddr_ready);
    @(posedge clk); #1;
    wraddr_valid = 1'b0; wr_dat = d; wr_strb = s; wr_valid = 1'b1;
    @(negedge clk);
    wait_hi("wr_ready", wr_ready);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    wait_hi("wrresp_valid", wrresp_valid);
    resp = wrresp_dat;
    for (int i = 0; i < stall; i++) begin
      wraddr_valid = 1'b1; rdaddr_valid = 1'b1; #1;
      chk("wstall_valid", 64'(wrresp_valid), 64'd1);
      chk("wstall_resp", 64'(wrresp_dat), 64'(resp));
      chk("wstall_addr_rdy", 64'({wraddr_ready, rdaddr_ready}), 64'd0);
      @(negedge clk);
    end
    wraddr_valid = 1'b0; rdaddr_valid = 1'b0; wrresp_ready = 1'b1;
    @(posedge clk); #1;
    wrresp_ready = 1'b0;
  endtask

  task automatic rd_txn(input logic [AW-1:0] a, input int stall,
                        output logic [DW-1:0] d, output logic [1:0] resp);
    @(negedge clk);
    rdaddr = a; rdaddr_valid = 1'b1;
    wait_hi("rdaddr_ready", rdaddr_ready);
    @(posedge clk); #1;
    rdaddr_valid = 1'b0;
    @(negedge clk);
    wait_hi("rd_valid", rd_valid);
    d = rd_dat; resp = rdresp_dat;
    for (int i = 0; i < stall; i++) begin
      wraddr_valid = 1'b1; rdaddr_valid = 1'b1; #1;
      chk("rstall_valid", 64'(rd_valid), 64'd1);
      chk("rstall_data", 64'({rdresp_dat, rd_dat}), 64'({resp, d}));
      chk("rstall_addr_rdy", 64'({wraddr_ready, rdaddr_ready}), 64'd0);
      @(negedge clk);
    end
    wraddr_valid = 1'b0; rdaddr_valid = 1'b0; rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] d;
    logic [1:0]    r;
    logic [DW/8-1:0] full = '1;

    vecs[0]  = '{1'b1, 38'h104,          32'hF000BAAA, 2'b00, 32'h0};
    vecs[1]  = '{1'b0, 38'h104,          32'h0,        2'b00, 32'hF000BAAA};
    vecs[2]  = '{1'b0, 38'h100,          32'h0,        2'b00, 32'h0};
    vecs[3]  = '{1'b1, 38'h140,          32'hDEADBEEF, 2'b11, 32'h0};
    vecs[4]  = '{1'b0, 38'h140,          32'h0,        2'b11, 32'h0};
    vecs[5]  = '{1'b1, 38'h0FC,          32'h00000055, 2'b11, 32'h0};
    vecs[6]  = '{1'b0, 38'h0FC,          32'h0,        2'b11, 32'h0};
    vecs[7]  = '{1'b1, 38'h13C,          32'hA5A5A5A5, 2'b00, 32'h0};
    vecs[8]  = '{1'b0, 38'h13F,          32'h0,        2'b00, 32'hA5A5A5A5};
    vecs[9]  = '{1'b1, 38'h107,          32'h0BADF00D, 2'b00, 32'h0};
    vecs[10] = '{1'b0, 38'h104,          32'h0,        2'b00, 32'h0BADF00D};
    vecs[11] = '{1'b0, 38'h100,          32'h0,        2'b00, 32'h0};
    vecs[12] = '{1'b0, 38'h3FFFFFFFFC,   32'h0,        2'b11, 32'h0};
    vecs[13] = '{1'b0, 38'h13C,          32'h0,        2'b00, 32'hA5A5A5A5};
    for (int i = 0; i < NR; i++) model[i] = '0;

    // reset values
    #3;
    chk("rst_addr_rdy", 64'({wraddr_ready, rdaddr_ready}), 64'd0);
    chk("rst_valids", 64'({wr_ready, wrresp_valid, rd_valid}), 64'd0);
    chk("rst_resp", 64'({wrresp_dat, rdresp_dat}), 64'd0);
    chk("rst_rd_dat", 64'(rd_dat), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; #1;
    chk("idle_addr_rdy", 64'({wraddr_ready, rdaddr_ready}), 64'b11);

    // table of single transactions
    for (int i = 0; i < 14; i++) begin
      if (vecs[i].wr) begin
        wr_txn(vecs[i].addr, vecs[i].data, full, 0, r);
        chk($sformatf("v%0d_wresp", i), 64'(r), 64'(vecs[i].resp));
        if (vecs[i].resp == 2'b00) model[(vecs[i].addr - BASE) >> 2] = vecs[i].data;
      end else begin
        rd_txn(vecs[i].addr, 0, d, r);
        chk($sformatf("v%0d_rresp", i), 64'(r), 64'(vecs[i].resp));
        chk($sformatf("v%0d_rdat", i), 64'(d), 64'(vecs[i].rdat));
      end
    end
    for (int i = 0; i < NR; i++) begin
      rd_txn(BASE + AW'(4 * i), 0, d, r);
      chk($sformatf("sweep%0d", i), 64'({r, d}), 64'({2'b00, model[i]}));
    end

    // simultaneous write and read to reg 2: write first, read sees new value
    @(negedge clk);
    wraddr = 38'h108; wraddr_valid = 1'b1; rdaddr = 38'h108; rdaddr_valid = 1'b1; #1;
    chk("both_rdaddr_rdy", 64'({wraddr_ready, rdaddr_ready}), 64'b10);
    @(posedge clk); #1;
    wraddr_valid = 1'b0; wr_dat = 32'h12345678; wr_strb = full; wr_valid = 1'b1;
    chk("wdata_rdys", 64'({wr_ready, wraddr_ready, rdaddr_ready}), 64'b100);
    @(posedge clk); #1;
    wr_valid = 1'b0;
    chk("wresp_next", 64'({wrresp_valid, wrresp_dat}), 64'b100);
    wrresp_ready = 1'b1;
    @(posedge clk); #1;
    wrresp_ready = 1'b0;
    chk("pend_rdaddr_rdy", 64'(rdaddr_ready), 64'd1);
    @(posedge clk); #1;
    rdaddr_valid = 1'b0;
    chk("pend_rd", 64'({rd_valid, rdresp_dat, rd_dat}), {31'd0, 1'b1, 2'b00, 32'h12345678});
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    chk("pend_done", 64'(rd_valid), 64'd0);
    model[2] = 32'h12345678;

    // stalled responses
    wr_txn(38'h10C, 32'hC0FFEE01, full, 5, r);
    chk("stall_wresp", 64'(r), 64'd0);
    rd_txn(38'h10C, 5, d, r);
    chk("stall_rd", 64'({r, d}), 64'({2'b00, 32'hC0FFEE01}));
    rd_txn(38'h200, 5, d, r);
    chk("stall_rd_dec", 64'({r, d}), 64'({2'b11, 32'h0}));

`ifdef CRYPTO_REGFILE_WSTRB_EN
    wr_txn(38'h118, 32'hAABBCCDD, 4'hF, 0, r);
    wr_txn(38'h118, 32'h11223344, 4'b0101, 0, r);
    chk("strb_resp", 64'(r), 64'd0);
    rd_txn(38'h118, 0, d, r);
    chk("strb_rd", 64'(d), 64'(32'hAA22CC44));
    wr_txn(38'h118, 32'h99999999, 4'b0000, 0, r);
    chk("strb0_resp", 64'(r), 64'd0);
    rd_txn(38'h118, 0, d, r);
    chk("strb0_rd", 64'(d), 64'(32'hAA22CC44));
`endif

    // reset in WDATA abandons the write; first address handshake on first edge after release
    @(negedge clk);
    wraddr = 38'h114; wraddr_valid = 1'b1;
    @(posedge clk); #1;
    wraddr_valid = 1'b0;
    chk("pre_rst_wdata", 64'(wr_ready), 64'd1);
    @(negedge clk);
    wr_dat = 32'hCAFECAFE; wr_valid = 1'b1; rst_n = 1'b0; #1;
    chk("rst_mid_rdys", 64'({wr_ready, wraddr_ready, rdaddr_ready, wrresp_valid, rd_valid}), 64'd0);
    @(negedge clk);
    wr_valid = 1'b0; rst_n = 1'b1;
    rdaddr = 38'h114; rdaddr_valid = 1'b1;
    @(posedge clk); #1;
    rdaddr_valid = 1'b0;
    chk("first_edge_rd", 64'({wrresp_valid, rd_valid, rdresp_dat, rd_dat}), {30'd0, 2'b01, 2'b00, 32'h0});
    rd_ready = 1'b1;
    @(posedge clk); #1;
    rd_ready = 1'b0;
    rd_txn(38'h10C, 0, d, r);
    chk("rst_cleared", 64'({r, d}), 64'd0);
    repeat (3) @(negedge clk);
    chk("no_late_resp", 64'({wrresp_valid, rd_valid}), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got timeout expected finish");
    $fatal(1);
  end

endmodule
